// File: rtl/uart_rx_ctrl_if.sv
// Handshake and status bundle between the UART receiver, its consumer
// and the RX buffering controller.
interface uart_rx_ctrl_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          cfg_en_i;
    logic [CW-1:0] cfg_thresh_i;
    logic          clear_i;
    logic [7:0]    rx_data_i;
    logic          rx_data_valid_i;
    logic          int_parity_err_i;
    logic [7:0]    rx_data_o;
    logic          rx_valid_o;
    logic          rx_ready_i;
    logic [CW-1:0] count_o;
    logic          overflow_o;
    logic [7:0]    parity_err_cnt_o;
    logic          int_thresh_o;
    logic          int_timeout_o;

    modport master (
        output cfg_en_i, cfg_thresh_i, clear_i,
        output rx_data_i, rx_data_valid_i,
        output int_parity_err_i, rx_ready_i,
        input  rx_data_o, rx_valid_o, count_o,
        input  overflow_o, parity_err_cnt_o,
        input  int_thresh_o, int_timeout_o
    );

    modport slave (
        input  cfg_en_i, cfg_thresh_i, clear_i,
        input  rx_data_i, rx_data_valid_i,
        input  int_parity_err_i, rx_ready_i,
        output rx_data_o, rx_valid_o, count_o,
        output overflow_o, parity_err_cnt_o,
        output int_thresh_o, int_timeout_o
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX byte FIFO with overflow/parity status, fill-level
// threshold interrupt and idle-timeout interrupt.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic clk_i,
    input  logic arst_i,
    uart_rx_ctrl_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        TIMEOUT
    } state_e;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overflow_q;
    logic [7:0]    perr_q;
    logic          thresh_q;
    state_e        state_q;
    state_e        state_d;
    logic [TW-1:0] idle_q;
    logic [TW-1:0] idle_d;

    logic valid;
    logic full;
    logic push;
    logic pop;
    logic wr_en;
    logic perr_inc;

    assign valid    = (count_q != '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign push     = bus.rx_data_valid_i & bus.cfg_en_i & ~bus.clear_i;
    assign pop      = valid & bus.rx_ready_i & ~bus.clear_i;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign wr_en    = push & (~full | pop);
    assign perr_inc = bus.int_parity_err_i & bus.cfg_en_i & ~bus.clear_i;

    always_comb begin
        count_d = count_q;
        if (bus.clear_i) begin
            count_d = '0;
        end else if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= bus.rx_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            perr_q     <= '0;
            thresh_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            thresh_q <= (bus.cfg_thresh_i != '0) &&
                        (count_d >= bus.cfg_thresh_i);
            if (bus.clear_i) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                overflow_q <= 1'b0;
                perr_q     <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                if (push && full && !pop) begin
                    overflow_q <= 1'b1;
                end
                if (perr_inc && perr_q != 8'hFF) begin
                    perr_q <= perr_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
        end
    end

    // Transitions look at the post-update fill level so an emptying
    // pop lands in IDLE directly.
    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        if (count_d == '0) begin
            state_d = IDLE;
            idle_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = COUNT;
                    idle_d  = '0;
                end
                COUNT: begin
                    if (push || pop) begin
                        idle_d = '0;
                    end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = TIMEOUT;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                TIMEOUT: begin
                    if (push || pop) begin
                        state_d = COUNT;
                        idle_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idle_d  = '0;
                end
            endcase
        end
    end

    assign bus.rx_data_o        = valid ? mem[rd_ptr_q] : 8'h00;
    assign bus.rx_valid_o       = valid;
    assign bus.count_o          = count_q;
    assign bus.overflow_o       = overflow_q;
    assign bus.parity_err_cnt_o = perr_q;
    assign bus.int_thresh_o     = thresh_q;
    assign bus.int_timeout_o    = (state_q == TIMEOUT);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl
// (FIFO_DEPTH=8, TIMEOUT_CYCLES=32).
module tb_uart_rx_ctrl;
    logic clk;
    logic arst;
    int   n_chk;
    int   n_fail;

    uart_rx_ctrl_if #(.FIFO_DEPTH(8)) u_if ();

    uart_rx_ctrl #(
        .FIFO_DEPTH    (8),
        .TIMEOUT_CYCLES(32)
    ) u_dut (
        .clk_i (clk),
        .arst_i(arst),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        u_if.rx_data_i       = d;
        u_if.rx_data_valid_i = 1'b1;
        step();
        u_if.rx_data_valid_i = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        arst   = 1'b1;
        u_if.cfg_en_i         = 1'b1;
        u_if.cfg_thresh_i     = '0;
        u_if.clear_i          = 1'b0;
        u_if.rx_data_i        = '0;
        u_if.rx_data_valid_i  = 1'b0;
        u_if.int_parity_err_i = 1'b0;
        u_if.rx_ready_i       = 1'b0;
        #23;
        chk("rst_valid", 32'(u_if.rx_valid_o), 0);
        chk("rst_count", 32'(u_if.count_o), 0);
        chk("rst_tmo", 32'(u_if.int_timeout_o), 0);
        arst = 1'b0;
        step();

        // in-order delivery with consumer stalled, then streaming
        push_byte(8'h11);
        chk("q_first_valid", 32'(u_if.rx_valid_o), 1);
        push_byte(8'h22);
        push_byte(8'h33);
        chk("q_count3", 32'(u_if.count_o), 3);
        u_if.rx_ready_i = 1'b1;
        chk("q_d0", 32'(u_if.rx_data_o), 32'h11);
        step();
        chk("q_d1", 32'(u_if.rx_data_o), 32'h22);
        step();
        chk("q_d2", 32'(u_if.rx_data_o), 32'h33);
        step();
        u_if.rx_ready_i = 1'b0;
        chk("q_empty_valid", 32'(u_if.rx_valid_o), 0);
        chk("q_empty_count", 32'(u_if.count_o), 0);

        // fill, overflow, push+pop while full, pointer wrap
        for (int i = 0; i < 8; i++) push_byte(8'(i));
        chk("f_count8", 32'(u_if.count_o), 8);
        chk("f_no_ovf", 32'(u_if.overflow_o), 0);
        push_byte(8'h08);
        chk("f_ovf", 32'(u_if.overflow_o), 1);
        chk("f_count_ovf", 32'(u_if.count_o), 8);
        chk("f_head0", 32'(u_if.rx_data_o), 32'h00);
        u_if.rx_ready_i = 1'b1;
        push_byte(8'h09);
        chk("f_pp_count", 32'(u_if.count_o), 8);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("f_out%0d", i), 32'(u_if.rx_data_o), i);
            step();
        end
        chk("f_last09", 32'(u_if.rx_data_o), 32'h09);
        step();
        u_if.rx_ready_i = 1'b0;
        chk("f_drained", 32'(u_if.rx_valid_o), 0);
        chk("f_ovf_sticky", 32'(u_if.overflow_o), 1);

        // fill-level threshold
        u_if.cfg_thresh_i = 4'd4;
        push_byte(8'hA0);
        push_byte(8'hA1);
        push_byte(8'hA2);
        chk("t_below", 32'(u_if.int_thresh_o), 0);
        push_byte(8'hA3);
        chk("t_at", 32'(u_if.int_thresh_o), 1);
        u_if.rx_ready_i = 1'b1;
        step();
        chk("t_after_pop", 32'(u_if.int_thresh_o), 0);
        step();
        step();
        step();
        u_if.rx_ready_i   = 1'b0;
        u_if.cfg_thresh_i = '0;
        chk("t_drained", 32'(u_if.count_o), 0);

        // capture disabled drops incoming bytes
        u_if.cfg_en_i = 1'b0;
        push_byte(8'h5A);
        chk("en_off_drop", 32'(u_if.count_o), 0);
        u_if.cfg_en_i = 1'b1;

        // idle timeout
        push_byte(8'h77);
        for (int k = 1; k < 32; k++) step();
        chk("tmo_before", 32'(u_if.int_timeout_o), 0);
        step();
        chk("tmo_raised", 32'(u_if.int_timeout_o), 1);
        u_if.rx_ready_i = 1'b1;
        step();
        u_if.rx_ready_i = 1'b0;
        chk("tmo_pop_drop", 32'(u_if.int_timeout_o), 0);
        chk("tmo_pop_empty", 32'(u_if.count_o), 0);
        step();
        chk("tmo_idle", 32'(u_if.int_timeout_o), 0);

        // parity counter: gated by enable, saturates
        u_if.cfg_en_i         = 1'b0;
        u_if.int_parity_err_i = 1'b1;
        step();
        u_if.cfg_en_i = 1'b1;
        chk("p_gated", 32'(u_if.parity_err_cnt_o), 0);
        for (int i = 0; i < 300; i++) step();
        u_if.int_parity_err_i = 1'b0;
        chk("p_sat", 32'(u_if.parity_err_cnt_o), 255);

        // clear wins over a same-cycle push
        push_byte(8'hC0);
        u_if.clear_i         = 1'b1;
        u_if.rx_data_valid_i = 1'b1;
        step();
        u_if.clear_i         = 1'b0;
        u_if.rx_data_valid_i = 1'b0;
        chk("c_count", 32'(u_if.count_o), 0);
        chk("c_perr", 32'(u_if.parity_err_cnt_o), 0);
        chk("c_ovf", 32'(u_if.overflow_o), 0);
        chk("c_valid", 32'(u_if.rx_valid_o), 0);

        // asynchronous reset with data buffered
        for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i));
        chk("r_count5", 32'(u_if.count_o), 5);
        #2 arst = 1'b1;
        #1;
        chk("r_valid", 32'(u_if.rx_valid_o), 0);
        chk("r_count", 32'(u_if.count_o), 0);
        chk("r_data", 32'(u_if.rx_data_o), 0);
        chk("r_ovf", 32'(u_if.overflow_o), 0);
        chk("r_perr", 32'(u_if.parity_err_cnt_o), 0);
        chk("r_thr", 32'(u_if.int_thresh_o), 0);
        chk("r_tmo", 32'(u_if.int_timeout_o), 0);
        #2 arst = 1'b0;
        step();
        push_byte(8'hA5);
        chk("r_post_data", 32'(u_if.rx_data_o), 32'hA5);
        chk("r_post_count", 32'(u_if.count_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8; number of received-byte entries; power of 2, at least 2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32; idle cycles before the RX timeout is raised; at least 2.
REQ-003 SHALL have ports (name  direction  width  meaning):
- clk_i  in  1  sole clock, rising edge.
- arst_i  in  1  asynchronous, active-high reset.
- cfg_en_i  in  1  capture enable; low means incoming bytes and parity errors are ignored.
- cfg_thresh_i  in  $clog2(FIFO_DEPTH)+1  fill-level interrupt threshold.
- clear_i  in  1  synchronous flush/clear pulse.
- rx_data_i  in  8  byte from the UART receiver.
- rx_data_valid_i  in  1  one-cycle strobe; rx_data_i is valid.
- int_parity_err_i  in  1  one-cycle strobe from the receiver; parity failure.
- rx_data_o  out  8  head-of-FIFO byte.
- rx_valid_o  out  1  FIFO not empty.
- rx_ready_i  in  1  consumer accepts the head byte.
- count_o  out  $clog2(FIFO_DEPTH)+1  current fill level.
- overflow_o  out  1  sticky flag; a byte was dropped.
- parity_err_cnt_o  out  8  saturating count of parity errors.
- int_thresh_o  out  1  level interrupt; fill level at or above threshold.
- int_timeout_o  out  1  level interrupt; data stale in the FIFO.

Function
REQ-004 SHALL treat push = rx_data_valid_i & cfg_en_i & ~clear_i.
REQ-005 SHALL treat pop = rx_valid_o & rx_ready_i & ~clear_i.
REQ-006 SHALL register pushed data; a byte pushed into an empty FIFO appears on rx_data_o with rx_valid_o=1 on the next cycle (no fall-through).
REQ-007 SHALL drive rx_data_o from the read-pointer entry; rx_data_o is don't-care when rx_valid_o=0.
REQ-008 SHALL, on push with pop in the same cycle, accept both in all fill states, including full; count is unchanged.
REQ-009 SHALL, on push without pop when count_o==FIFO_DEPTH, drop the byte, set overflow_o, and leave the FIFO contents unchanged.
REQ-010 SHALL wrap the read and write pointers modulo FIFO_DEPTH; count_o ranges 0..FIFO_DEPTH.
REQ-011 SHALL increment parity_err_cnt_o on int_parity_err_i & cfg_en_i; it saturates at 255 and never wraps.
REQ-012 SHALL never push the byte associated with a parity error; the receiver withholds rx_data_valid_i in that case.
REQ-013 SHALL assert int_thresh_o = (cfg_thresh_i != 0) & (count_o >= cfg_thresh_i), registered from the post-update count.
REQ-014 SHALL run the timeout FSM with three states: IDLE, COUNT and TIMEOUT.
- IDLE to COUNT when count_o becomes non-zero; the idle counter loads 0.
- In COUNT, any push or pop reloads the counter to 0; otherwise the counter increments.
- COUNT to TIMEOUT when the counter reaches TIMEOUT_CYCLES-1.
- TIMEOUT to COUNT on a pop that leaves the FIFO non-empty, or on a push.
- Any state to IDLE when the FIFO becomes empty.
REQ-015 SHALL assert int_timeout_o exactly while the FSM is in TIMEOUT.
REQ-016 SHALL make clear_i take priority over all same-cycle events. On the next cycle:
- FIFO empty and pointers 0;
- overflow_o=0 and parity_err_cnt_o=0;
- FSM in IDLE;
- the same-cycle push, pop and parity strobe are discarded.
REQ-017 SHALL let cfg_en_i=0 stop capture only; popping, draining and the timeout continue normally.
REQ-018 SHALL let cfg_thresh_i change at any time, taking effect on the following cycle.

Reset
REQ-019 SHALL, while arst_i=1, asynchronously force:
- rx_valid_o=0, count_o=0, overflow_o=0;
- parity_err_cnt_o=0, int_thresh_o=0, int_timeout_o=0;
- rx_data_o=0, pointers=0, FSM=IDLE.
REQ-020 SHALL, on reset asserted mid-operation, discard all buffered bytes; the first valid output after release is the first byte pushed after release.
REQ-021 SHALL require no clock edge for reset to take effect; normal operation resumes on the first rising edge after arst_i falls.

Verification
REQ-022 Push 0x11, 0x22, 0x33 with rx_ready_i=0, then hold rx_ready_i=1 -> rx_data_o shows 0x11, 0x22, 0x33 on consecutive cycles, then rx_valid_o=0 and count_o=0.
REQ-023 Fill 8 bytes (0x00..0x07); push 0x08 with no pop -> overflow_o=1, count_o=8, output order 0x00..0x07. Then push 0x09 with a simultaneous pop -> accepted, count_o stays 8, last byte out is 0x09.
REQ-024 cfg_thresh_i=4; push 4 bytes -> int_thresh_o=1 the cycle after the 4th push. One pop -> int_thresh_o=0.
REQ-025 Push one byte with rx_ready_i=0 and no further activity -> int_timeout_o=1 exactly TIMEOUT_CYCLES cycles after rx_valid_o rises. A pop -> int_timeout_o=0 and FSM returns to IDLE.
REQ-026 Issue 300 int_parity_err_i strobes -> parity_err_cnt_o=255. Then clear_i coinciding with a push -> count_o=0, counter=0, overflow_o=0.
REQ-027 Assert arst_i asynchronously with 5 bytes buffered -> all outputs go to their reset values before the next clock edge. After release, push 0xA5 -> rx_data_o=0xA5 and count_o=1.
